// File: rtl/ethertype_extractor_pkg.sv
// Shared types and constants for the EtherType extraction tap.
package ethertype_extractor_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned TYPE_W     = 16;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned VLAN_CNT_W = 2;

    localparam int unsigned ETH_ADDR_BYTES = 6;
    localparam int unsigned VLAN_TCI_BYTES = 2;

    localparam logic [TYPE_W-1:0] RUNT_TYPE   = 16'h05FF;
    localparam logic [TYPE_W-1:0] TPID_8021Q  = 16'h8100;
    localparam logic [TYPE_W-1:0] TPID_8021AD = 16'h88A8;

    typedef enum logic [2:0] {
        ST_DST     = 3'd0,
        ST_SRC     = 3'd1,
        ST_TYPE_HI = 3'd2,
        ST_TYPE_LO = 3'd3,
        ST_TCI     = 3'd4,
        ST_PAYLOAD = 3'd5
    } eth_hdr_state_t;

    // tuser marks a runt frame whose tdata is the guaranteed-invalid RUNT_TYPE
    typedef struct packed {
        logic              tvalid;
        logic [TYPE_W-1:0] tdata;
        logic              tuser;
    } packet_source_t;

endpackage

// File: rtl/ethertype_extractor.sv
// Passive header tap: walks the Ethernet header, skips VLAN tags and emits
// one EtherType/length record per frame (RUNT_TYPE for truncated headers).
module ethertype_extractor
    import ethertype_extractor_pkg::*;
#(
    parameter int unsigned       MAX_VLAN_TAGS = 2,
    parameter logic [TYPE_W-1:0] VLAN_TPID_A   = TPID_8021Q,
    parameter logic [TYPE_W-1:0] VLAN_TPID_B   = TPID_8021AD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_W-1:0]     in_tdata,
    input  logic                  in_tvalid,
    input  logic                  in_tready,
    input  logic                  in_tlast,
    output packet_source_t        type_pkt,
    output logic [VLAN_CNT_W-1:0] vlan_count,
    output logic                  frame_active
);

    eth_hdr_state_t        state_q, state_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [BYTE_W-1:0]     type_hi_q, type_hi_d;
    logic [VLAN_CNT_W-1:0] vlan_count_q, vlan_count_d;
    logic                  tvalid_q, tvalid_d;
    logic [TYPE_W-1:0]     tdata_q, tdata_d;
    logic                  tuser_q, tuser_d;
    logic                  frame_active_q, frame_active_d;

    logic                  accept;
    logic [TYPE_W-1:0]     type_word;
    logic                  is_tpid;
    logic                  tag_room;
    logic                  emit_type;
    logic                  take_tag;

    assign accept    = in_tvalid && in_tready;
    assign type_word = {type_hi_q, in_tdata};
    assign is_tpid   = (type_word == VLAN_TPID_A) || (type_word == VLAN_TPID_B);
    assign tag_room  = 32'(vlan_count_q) < MAX_VLAN_TAGS;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_DST;
            byte_cnt_q     <= '0;
            type_hi_q      <= '0;
            vlan_count_q   <= '0;
            tvalid_q       <= 1'b0;
            tdata_q        <= '0;
            tuser_q        <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            type_hi_q      <= type_hi_d;
            vlan_count_q   <= vlan_count_d;
            tvalid_q       <= tvalid_d;
            tdata_q        <= tdata_d;
            tuser_q        <= tuser_d;
            frame_active_q <= frame_active_d;
        end
    end

    // Header walk; everything holds unless a beat is accepted
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        type_hi_d      = type_hi_q;
        vlan_count_d   = vlan_count_q;
        tvalid_d       = 1'b0;
        tdata_d        = tdata_q;
        tuser_d        = tuser_q;
        frame_active_d = frame_active_q;
        emit_type      = 1'b0;
        take_tag       = 1'b0;

        if (accept) begin
            frame_active_d = !in_tlast;
            if (!frame_active_q) begin
                vlan_count_d = '0;
            end

            case (state_q)
                ST_DST: begin
                    if (byte_cnt_q == CNT_W'(ETH_ADDR_BYTES - 1)) begin
                        state_d    = ST_SRC;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
                ST_SRC: begin
                    if (byte_cnt_q == CNT_W'(ETH_ADDR_BYTES - 1)) begin
                        state_d    = ST_TYPE_HI;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
                ST_TYPE_HI: begin
                    type_hi_d  = in_tdata;
                    state_d    = ST_TYPE_LO;
                    byte_cnt_d = '0;
                end
                ST_TYPE_LO: begin
                    if (is_tpid && tag_room) begin
                        take_tag = 1'b1;
                    end else begin
                        emit_type = 1'b1;
                    end
                end
                ST_TCI: begin
                    if (byte_cnt_q == CNT_W'(VLAN_TCI_BYTES - 1)) begin
                        state_d    = ST_TYPE_HI;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
                ST_PAYLOAD: begin
                    byte_cnt_d = '0;
                end
                default: begin
                    state_d    = ST_DST;
                    byte_cnt_d = '0;
                end
            endcase

            if (take_tag && !in_tlast) begin
                vlan_count_d = vlan_count_q + VLAN_CNT_W'(1);
                state_d      = ST_TCI;
                byte_cnt_d   = '0;
            end

            if (emit_type) begin
                tvalid_d   = 1'b1;
                tdata_d    = type_word;
                tuser_d    = 1'b0;
                state_d    = ST_PAYLOAD;
                byte_cnt_d = '0;
            end

            // Any frame end returns to DST; a truncated header reports a runt
            if (in_tlast) begin
                state_d    = ST_DST;
                byte_cnt_d = '0;
                if (state_q != ST_PAYLOAD && !emit_type) begin
                    tvalid_d = 1'b1;
                    tdata_d  = RUNT_TYPE;
                    tuser_d  = 1'b1;
                end
            end
        end
    end

    assign type_pkt.tvalid = tvalid_q;
    assign type_pkt.tdata  = tdata_q;
    assign type_pkt.tuser  = tuser_q;
    assign vlan_count      = vlan_count_q;
    assign frame_active    = frame_active_q;

endmodule

// File: tb/tb_ethertype_extractor.sv
// Directed bench for ethertype_extractor: untagged, tagged, tag limit, runt,
// stalls, async reset mid-frame and back-to-back frames.
module tb_ethertype_extractor;
    import ethertype_extractor_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [7:0]     in_tdata = '0;
    logic           in_tvalid = 1'b0;
    logic           in_tready = 1'b0;
    logic           in_tlast = 1'b0;
    packet_source_t type_pkt;
    logic [1:0]     vlan_count;
    logic           frame_active;

    int pass_cnt = 0;
    int check_cnt = 0;
    int unsigned cyc = 0;

    logic [7:0]  frm [0:127];
    int unsigned byte_cyc [0:127];
    logic        fa_after [0:127];

    logic [15:0] log_data [$];
    logic        log_user [$];
    int unsigned log_cyc  [$];
    logic [1:0]  log_vlan [$];

    ethertype_extractor #(.MAX_VLAN_TAGS(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_tdata     (in_tdata),
        .in_tvalid    (in_tvalid),
        .in_tready    (in_tready),
        .in_tlast     (in_tlast),
        .type_pkt     (type_pkt),
        .vlan_count   (vlan_count),
        .frame_active (frame_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every emitted pulse with the cycle it became visible
    always @(negedge clk) begin
        if (type_pkt.tvalid) begin
            log_data.push_back(type_pkt.tdata);
            log_user.push_back(type_pkt.tuser);
            log_cyc.push_back(cyc);
            log_vlan.push_back(vlan_count);
        end
    end

    task automatic fill_frame(input logic [15:0] etype);
        for (int i = 0; i < 128; i++) frm[i] = 8'(i + 16);
        frm[12] = etype[15:8];
        frm[13] = etype[7:0];
    endtask

    task automatic put16(input int idx, input logic [15:0] v);
        frm[idx]     = v[15:8];
        frm[idx + 1] = v[7:0];
    endtask

    // Drive len bytes from negedge to negedge; optional random back-pressure
    task automatic send_frame(input int len, input bit stall, input bit with_last);
        for (int i = 0; i < len; i++) begin
            in_tdata  = frm[i];
            in_tlast  = with_last && (i == len - 1);
            in_tvalid = 1'b1;
            if (stall) begin
                for (int k = 0; k < 3; k++) begin
                    if ($urandom_range(1, 0) == 0) break;
                    in_tready = 1'b0;
                    @(negedge clk);
                end
            end
            in_tready = 1'b1;
            @(negedge clk);
            byte_cyc[i] = cyc;
            fa_after[i] = frame_active;
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_cnt++;
        if (type_pkt !== '0) $display("FAIL reset_type_pkt got %h want 0", type_pkt);
        else pass_cnt++;
        check_cnt++;
        if (vlan_count !== 2'd0) $display("FAIL reset_vlan got %0d want 0", vlan_count);
        else pass_cnt++;
        check_cnt++;
        if (frame_active !== 1'b0) $display("FAIL reset_frame_active got %b want 0", frame_active);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_untagged(input bit stall, input string tag);
        int s;
        s = log_data.size();
        fill_frame(16'h0800);
        send_frame(64, stall, 1'b1);
        repeat (2) @(negedge clk);
        check_cnt++;
        if (log_data.size() - s !== 1) $display("FAIL %s_pulse_count got %0d want 1", tag, log_data.size() - s);
        else pass_cnt++;
        check_cnt++;
        if (log_data[s] !== 16'h0800) $display("FAIL %s_tdata got %h want 0800", tag, log_data[s]);
        else pass_cnt++;
        check_cnt++;
        if (log_user[s] !== 1'b0) $display("FAIL %s_tuser got %b want 0", tag, log_user[s]);
        else pass_cnt++;
        check_cnt++;
        if (log_cyc[s] !== byte_cyc[13]) $display("FAIL %s_pulse_cycle got %0d want %0d", tag, log_cyc[s], byte_cyc[13]);
        else pass_cnt++;
        check_cnt++;
        if (log_vlan[s] !== 2'd0) $display("FAIL %s_vlan got %0d want 0", tag, log_vlan[s]);
        else pass_cnt++;
        check_cnt++;
        if (fa_after[62] !== 1'b1 || fa_after[63] !== 1'b0)
            $display("FAIL %s_frame_active got %b%b want 10", tag, fa_after[62], fa_after[63]);
        else pass_cnt++;
    endtask

    task automatic test_vlan;
        int s;
        // Single 802.1Q tag
        s = log_data.size();
        fill_frame(16'h8100);
        put16(14, 16'h0064);
        put16(16, 16'h86DD);
        send_frame(30, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_cnt++;
        if (log_data.size() - s !== 1 || log_data[s] !== 16'h86DD)
            $display("FAIL vlan1_tdata got %h (n=%0d) want 86dd (n=1)", log_data[s], log_data.size() - s);
        else pass_cnt++;
        check_cnt++;
        if (log_cyc[s] !== byte_cyc[17] || log_vlan[s] !== 2'd1)
            $display("FAIL vlan1_timing got cyc %0d vlan %0d want cyc %0d vlan 1", log_cyc[s], log_vlan[s], byte_cyc[17]);
        else pass_cnt++;
        // QinQ
        s = log_data.size();
        fill_frame(16'h88A8);
        put16(14, 16'h0123);
        put16(16, 16'h8100);
        put16(18, 16'h0064);
        put16(20, 16'h0800);
        send_frame(40, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_cnt++;
        if (log_data.size() - s !== 1 || log_data[s] !== 16'h0800)
            $display("FAIL qinq_tdata got %h (n=%0d) want 0800 (n=1)", log_data[s], log_data.size() - s);
        else pass_cnt++;
        check_cnt++;
        if (log_cyc[s] !== byte_cyc[21] || log_vlan[s] !== 2'd2)
            $display("FAIL qinq_timing got cyc %0d vlan %0d want cyc %0d vlan 2", log_cyc[s], log_vlan[s], byte_cyc[21]);
        else pass_cnt++;
        check_cnt++;
        if (vlan_count !== 2'd2) $display("FAIL qinq_vlan_hold got %0d want 2", vlan_count);
        else pass_cnt++;
    endtask

    task automatic test_tag_limit;
        int s;
        s = log_data.size();
        fill_frame(16'h8100);
        put16(14, 16'h0001);
        put16(16, 16'h8100);
        put16(18, 16'h0002);
        put16(20, 16'h8100);
        put16(22, 16'h0003);
        put16(24, 16'h0800);
        send_frame(40, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_cnt++;
        if (log_data.size() - s !== 1 || log_data[s] !== 16'h8100 || log_user[s] !== 1'b0)
            $display("FAIL tag_limit_tdata got %h tuser %b (n=%0d) want 8100 tuser 0 (n=1)",
                     log_data[s], log_user[s], log_data.size() - s);
        else pass_cnt++;
        check_cnt++;
        if (log_cyc[s] !== byte_cyc[21] || log_vlan[s] !== 2'd2)
            $display("FAIL tag_limit_timing got cyc %0d vlan %0d want cyc %0d vlan 2", log_cyc[s], log_vlan[s], byte_cyc[21]);
        else pass_cnt++;
    endtask

    task automatic test_runt;
        int s;
        s = log_data.size();
        fill_frame(16'h0800);
        send_frame(10, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_cnt++;
        if (log_data.size() - s !== 1 || log_data[s] !== 16'h05FF || log_user[s] !== 1'b1)
            $display("FAIL runt_pulse got %h tuser %b (n=%0d) want 05ff tuser 1 (n=1)",
                     log_data[s], log_user[s], log_data.size() - s);
        else pass_cnt++;
        check_cnt++;
        if (log_cyc[s] !== byte_cyc[9]) $display("FAIL runt_timing got %0d want %0d", log_cyc[s], byte_cyc[9]);
        else pass_cnt++;
        // Following frame must parse from byte 0
        s = log_data.size();
        fill_frame(16'h0806);
        send_frame(20, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_cnt++;
        if (log_data.size() - s !== 1 || log_data[s] !== 16'h0806 || log_user[s] !== 1'b0)
            $display("FAIL post_runt got %h tuser %b (n=%0d) want 0806 tuser 0 (n=1)",
                     log_data[s], log_user[s], log_data.size() - s);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame;
        int s;
        s = log_data.size();
        fill_frame(16'h0800);
        send_frame(8, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_cnt++;
        if (type_pkt !== '0 || frame_active !== 1'b0 || vlan_count !== 2'd0)
            $display("FAIL async_reset got pkt %h fa %b vlan %0d want all 0", type_pkt, frame_active, vlan_count);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (log_data.size() - s !== 0) $display("FAIL reset_no_pulse got %0d want 0", log_data.size() - s);
        else pass_cnt++;
        fill_frame(16'h0806);
        send_frame(20, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_cnt++;
        if (log_data.size() - s !== 1 || log_data[s] !== 16'h0806)
            $display("FAIL post_reset_tdata got %h (n=%0d) want 0806 (n=1)", log_data[s], log_data.size() - s);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int s;
        int unsigned c0;
        s = log_data.size();
        fill_frame(16'h0800);
        send_frame(14, 1'b0, 1'b1);
        c0 = byte_cyc[13];
        fill_frame(16'h05DC);
        send_frame(14, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_cnt++;
        if (log_data.size() - s !== 2) $display("FAIL b2b_count got %0d want 2", log_data.size() - s);
        else pass_cnt++;
        check_cnt++;
        if (log_data[s] !== 16'h0800 || log_user[s] !== 1'b0 || log_cyc[s] !== c0)
            $display("FAIL b2b_first got %h tuser %b cyc %0d want 0800 tuser 0 cyc %0d", log_data[s], log_user[s], log_cyc[s], c0);
        else pass_cnt++;
        check_cnt++;
        if (log_data[s+1] !== 16'h05DC || log_user[s+1] !== 1'b0 || log_cyc[s+1] !== byte_cyc[13])
            $display("FAIL b2b_second got %h tuser %b cyc %0d want 05dc tuser 0 cyc %0d",
                     log_data[s+1], log_user[s+1], log_cyc[s+1], byte_cyc[13]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_untagged(1'b0, "untagged");
        test_vlan();
        test_tag_limit();
        test_runt();
        test_untagged(1'b1, "stalled");
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
